// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a JK flip-flop's j/k from a queued {op, rep} FIFO and checking q against a shadow model.
// Optional macro JK_SEQ_ERR_CNT_EN builds the saturating mismatch counter behind err_cnt.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [REP_W-1:0] cmd_rep,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_t;

    function automatic logic jk_next(input logic [1:0] op, input logic q);
        case (op)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [REP_W+1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [REP_W-1:0] r_cnt;
    logic             r_shadow;
    logic             r_j;
    logic             r_k;
    logic             r_done;
    logic             r_err;

    state_t           w_state_nxt;
    logic [1:0]       w_op_nxt;
    logic [REP_W-1:0] w_cnt_nxt;
    logic             w_shadow_nxt;
    logic             w_j_nxt;
    logic             w_k_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [REP_W+1:0] w_head;
    logic [1:0]       w_head_op;
    logic [REP_W-1:0] w_head_rep;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = cmd_valid & ~w_full;
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_op  = w_head[REP_W+1:REP_W];
    assign w_head_rep = w_head[REP_W-1:0];

    // FIFO storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_rep};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_cnt    <= '0;
            r_shadow <= 1'b0;
            r_j      <= 1'b0;
            r_k      <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // j = op[1], k = op[0] maps HOLD/RESET/SET/TOGGLE straight onto the JK inputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_j_nxt      = r_j;
        w_k_nxt      = r_k;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_j_nxt = 1'b0;
                w_k_nxt = 1'b0;
                if (!w_empty) begin
                    w_state_nxt = S_DRIVE;
                    w_op_nxt    = w_head_op;
                    w_cnt_nxt   = w_head_rep;
                    w_j_nxt     = w_head_op[1];
                    w_k_nxt     = w_head_op[0];
                end
            end
            S_DRIVE: begin
                w_shadow_nxt = jk_next(r_op, r_shadow);
                w_cnt_nxt    = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_j_nxt     = 1'b0;
                    w_k_nxt     = 1'b0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
                w_err_nxt   = (q_fb != r_shadow);
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_j_nxt     = 1'b0;
                w_k_nxt     = 1'b0;
            end
        endcase
    end

`ifdef JK_SEQ_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_nxt) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign cmd_ready = ~w_full;
    assign busy      = (r_state != S_IDLE) | ~w_empty;
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer with a behavioural JK flip-flop on the j/k/q loop.
module tb_jk_cmd_sequencer;

    localparam int REP_W = 4;
`ifdef JK_SEQ_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [REP_W-1:0] cmd_rep = '0;
    logic             j;
    logic             k;
    logic             q_fb;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       err_cnt;

    jk_cmd_sequencer #(.DEPTH(4), .REP_W(REP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rep   (cmd_rep),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Behavioural JK flip-flop; force_q pins the fed-back q low to inject mismatches.
    logic ff_q;
    bit   force_q = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_fb = force_q ? 1'b0 : ff_q;

    typedef struct {
        int d_edge;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_d    = 0;
    bit   shadow_m  = 1'b0;
    int   n_err_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model(input logic [1:0] op, input logic [REP_W-1:0] rep, input bit s);
        case (op)
            2'b00:   return s;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return s ^ ~rep[0];
        endcase
    endfunction

    function automatic logic [31:0] exp_err_cnt();
        if (!CNT_EN) return 32'd0;
        return (n_err_exp > 255) ? 32'd255 : 32'(n_err_exp);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("done_edge", 32'(edge_n), 32'(mon_e.d_edge));
                    check_eq("err", 32'(err), 32'(mon_e.err));
                end
            end else if (err) begin
                check_eq("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    // Called at a negedge; leaves cmd_valid high so commands can be issued back to back.
    task automatic push_cmd(input logic [1:0] op, input logic [REP_W-1:0] rep);
        int   w = 0;
        int   pop_e;
        exp_t e;
        cmd_op    = op;
        cmd_rep   = rep;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check_eq("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pop_e    = (edge_n + 1 > last_d + 1) ? edge_n + 1 : last_d + 1;
        e.d_edge = pop_e + int'(rep) + 2;
        last_d   = e.d_edge;
        shadow_m = model(op, rep, shadow_m);
        e.err    = force_q && (shadow_m != 1'b0);
        if (e.err) n_err_exp++;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int c = 0;
        while (sb.size() != 0 && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic reset_model();
        sb.delete();
        shadow_m  = 1'b0;
        last_d    = 0;
        n_err_exp = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_j", 32'(j), 32'd0);
        check_eq("rst_k", 32'(k), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // SET rep=0: one drive cycle
        push_cmd(2'b10, 4'd0);
        cmd_valid = 1'b0;
        check_eq("set_j_pre", 32'({j, k}), 32'd0);
        @(negedge clk);
        check_eq("set_jk_drive", 32'({j, k}), 32'b10);
        @(negedge clk);
        check_eq("set_jk_after", 32'({j, k}), 32'd0);
        drain(20);
        check_eq("set_q", 32'(ff_q), 32'd1);

        // RESET then TOGGLE rep=2
        push_cmd(2'b01, 4'd0);
        cmd_valid = 1'b0;
        drain(20);
        check_eq("reset_q", 32'(ff_q), 32'd0);
        push_cmd(2'b11, 4'd2);
        cmd_valid = 1'b0;
        check_eq("tog_jk_pre", 32'({j, k}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("tog_jk_drive", 32'({j, k}), 32'b11);
        end
        @(negedge clk);
        check_eq("tog_jk_after", 32'({j, k}), 32'd0);
        drain(20);
        check_eq("tog_q", 32'(ff_q), 32'd1);

        // FIFO fill from reset with HOLD rep=15
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) push_cmd(2'b00, 4'd15);
        for (int i = 0; i < 3; i++) begin
            check_eq("full_ready", 32'(cmd_ready), 32'd0);
            check_eq("full_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_eq("fill_queued", 32'(sb.size()), 32'd5);
        drain(200);
        check_eq("fill_busy_end", 32'(busy), 32'd0);

        // Forced mismatch on SET rep=0
        force_q = 1'b1;
        push_cmd(2'b10, 4'd0);
        cmd_valid = 1'b0;
        drain(20);
        force_q = 1'b0;
        check_eq("err_cnt_one", 32'(err_cnt), exp_err_cnt());

        // Asynchronous reset mid-DRIVE with two entries queued
        push_cmd(2'b11, 4'd15);
        push_cmd(2'b00, 4'd1);
        push_cmd(2'b00, 4'd1);
        cmd_valid = 1'b0;
        check_eq("mid_drive_j", 32'(j), 32'd1);
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        check_eq("async_jk", 32'({j, k}), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_ready", 32'(cmd_ready), 32'd1);
        check_eq("async_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // 260 mismatches for counter saturation
        force_q = 1'b1;
        for (int i = 0; i < 260; i++) push_cmd(2'b10, 4'd0);
        cmd_valid = 1'b0;
        drain(2000);
        force_q = 1'b0;
        check_eq("err_cnt_sat", 32'(err_cnt), exp_err_cnt());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Command sequencer that sits directly upstream of the JK flip-flop stage and drives its `j`/`k` inputs. It accepts queued flip-flop commands (HOLD, RESET, SET, TOGGLE, each with a repeat count) over a valid/ready handshake. It applies each command to the flip-flop for the requested number of clock edges. It then reads the flip-flop's `q` back and checks it against an internal shadow model, reporting completion and mismatches.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO depth; power of 2, minimum 2.
- `REP_W`, 4: width of the repeat count field.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; `!full`, registered-state only.
- `cmd_op`  in  2  00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- `cmd_rep`  in  REP_W  number of drive edges minus 1.
- `j`  out  1  registered; to the flip-flop's J input.
- `k`  out  1  registered; to the flip-flop's K input.
- `q_fb`  in  1  flip-flop `q`, fed back.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `done`  out  1  one-cycle pulse per completed command.
- `err`  out  1  one-cycle pulse, coincident with `done`, on mismatch.
- `err_cnt`  out  8  saturating mismatch count (see Configuration).

## Operation
- FIFO entries: {op, rep}.
  - Push on `cmd_valid & cmd_ready`.
  - Pop only on the IDLE→DRIVE transition.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: `j=k=0`. If the FIFO is non-empty, pop, load `cnt=rep`, drive `j`/`k` from op, and go to DRIVE.
  - DRIVE: `j`/`k` are held for the whole state.
    - Each edge updates the shadow with the JK rule: HOLD keeps, RESET→0, SET→1, TOGGLE inverts.
    - Each edge decrements `cnt`.
    - On the edge where `cnt==0`, set `j=k=0` and go to CHECK.
  - CHECK: compare `q_fb` with the shadow.
    - On the next edge, go to IDLE.
    - Register `done=1`, and `err=1` if they differ.
- Every command spends exactly one cycle in IDLE between commands.
- Shadow value:
  - Reset value is 0, matching the flip-flop reset.
  - It is not resynchronized to `q_fb` after an error.

## Timing
- Reset values: `j=0`, `k=0`, `done=0`, `err=0`, `err_cnt=0`, `busy=0`, `cmd_ready=1`. FIFO is empty, FSM is in IDLE, shadow is 0.
- Reset asserted mid-operation:
  - Aborts the active command immediately and flushes the FIFO.
  - No `done` or `err` is generated for aborted commands.
- Latency:
  - A command accepted at edge E0 into an empty, idle block is popped at E1.
  - `j`/`k` are valid from E1 to E1+rep+1.
  - The flip-flop samples at edges E2 through E2+rep.
  - `done` is high in the cycle after edge E3+rep.
- Throughput: rep+3 cycles per command.
- `cmd_ready` is low whenever the FIFO holds DEPTH entries, even in a cycle where a pop occurs; it rises the cycle after.
- Upstream must hold `cmd_valid` and its payload stable until accepted.
- `q_fb` is sampled only in CHECK.

## Configuration
- `JK_SEQ_ERR_CNT_EN`:
  - Defined: `err_cnt` increments on each `err` pulse, in the same edge that registers `err`, and saturates at 255.
  - Undefined: the counter is not built and `err_cnt` is tied to 0.
  - `err` pulses are produced in both cases.

## Test plan
- Reset, then push SET rep=0 → `j=1,k=0` for exactly 1 cycle. `q_fb=1`. `done` pulses 3 cycles after the accept edge with `err=0`.
- From q=0, push TOGGLE rep=2 → `j=k=1` for 3 cycles. Flip-flop ends at q=1. `done=1`, `err=0`, 5 cycles after accept.
- Hold `cmd_valid=1` with HOLD rep=15 for 8 cycles from reset:
  - 5 commands accepted (1 popped, 4 stored).
  - `cmd_ready` stays 0 until the next pop.
  - All 5 `done` pulses arrive with no loss and no duplicates.
- Force `q_fb=0` during SET rep=0 → `err` and `done` pulse together. `err_cnt=1` with the macro defined, 0 without.
- Assert `rst` mid-DRIVE with 2 entries queued → `j=k=0` and `busy=0` asynchronously, `cmd_ready=1`. No `done` follows after release.
- With the macro defined, inject 260 mismatches → `err_cnt` holds at 255.
